pong_score_keeper: RTL and testbench

//  Synchronous two-digit BCD score counter for one player. Sits between the hit/point-reset
//  one-shots and the VGA 7-segment digit renderers. Replaces the edge-clocked score logic

---
 rtl/pong_score_keeper_pkg.sv | 11 +
 rtl/pong_score_keeper_bcd_digit.sv | 31 +++
 rtl/pong_score_keeper.sv | 116 +++++++++++
 tb/tb_pong_score_keeper.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_score_keeper_pkg.sv
// rtl/pong_score_keeper_pkg.sv - shared BCD limit and lockout FSM encoding for the score keeper
package pong_score_keeper_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    ST_ARMED   = 1'b0,
    ST_LOCKOUT = 1'b1
  } state_e;

endpackage

// File: rtl/pong_score_keeper_bcd_digit.sv
// rtl/pong_score_keeper_bcd_digit.sv - one BCD digit, 0..9, wrapping or saturating at 9
module bcd_digit
  import pong_score_keeper_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       sat,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] r_q;

  assign carry = inc && (r_q == BCD_MAX);
  assign q     = r_q;

  // Only 0..9 is ever loaded, so no illegal-code recovery is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 4'd0;
    end else if (inc) begin
      if (r_q == BCD_MAX) begin
        if (!sat) r_q <= 4'd0;
      end else begin
        r_q <= r_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pong_score_keeper.sv
// rtl/pong_score_keeper.sv - two-digit BCD score with hit lockout and post-score flash window
module pong_score_keeper
  import pong_score_keeper_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 1_000_000,
  parameter int FLASH_CYCLES   = 25_000_000,
  parameter bit WRAP           = 1'b1
) (
  input  logic       Clock,
  input  logic       pointresetShot1,
  input  logic       hit_pulse,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       score_changed,
  output logic       rollover,
  output logic       hit_dropped,
  output logic       flash
);

  localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam int FW = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;
  localparam logic [LW-1:0] LOCK_LOAD  = LW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
  localparam logic [FW-1:0] FLASH_LOAD = FW'((FLASH_CYCLES > 0) ? FLASH_CYCLES - 1 : 0);

  state_e          r_state, w_state_nxt;
  logic [LW-1:0]   r_lock_cnt, w_lock_nxt;
  logic [FW-1:0]   r_flash_cnt;
  logic            w_accept, w_drop, w_inc, w_at_max;
  logic            w_ones_carry, w_tens_carry;
  logic            r_changed, r_rollover, r_dropped, r_flash;

  always_ff @(posedge Clock or posedge pointresetShot1) begin
    if (pointresetShot1) begin
      r_state    <= ST_ARMED;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_nxt;
    end
  end

  // A hit seen on the last lockout cycle is still dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_cnt;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_ARMED: begin
        if (hit_pulse) begin
          w_accept = 1'b1;
          if (LOCKOUT_CYCLES != 0) begin
            w_state_nxt = ST_LOCKOUT;
            w_lock_nxt  = LOCK_LOAD;
          end
        end
      end
      ST_LOCKOUT: begin
        w_drop = hit_pulse;
        if (r_lock_cnt != '0) w_lock_nxt = r_lock_cnt - LW'(1);
        else                  w_state_nxt = ST_ARMED;
      end
      default: w_state_nxt = ST_ARMED;
    endcase
  end

  // Saturating at 99 suppresses the ones digit too, otherwise 99 would become 90.
  assign w_at_max = (digit_ones == BCD_MAX) && (digit_tens == BCD_MAX);
  assign w_inc    = w_accept && !(!WRAP && w_at_max);

  bcd_digit u_ones (
    .clk   (Clock),
    .rst   (pointresetShot1),
    .inc   (w_inc),
    .sat   (1'b0),
    .q     (digit_ones),
    .carry (w_ones_carry)
  );

  bcd_digit u_tens (
    .clk   (Clock),
    .rst   (pointresetShot1),
    .inc   (w_ones_carry),
    .sat   (!WRAP),
    .q     (digit_tens),
    .carry (w_tens_carry)
  );

  always_ff @(posedge Clock or posedge pointresetShot1) begin
    if (pointresetShot1) begin
      r_changed   <= 1'b0;
      r_rollover  <= 1'b0;
      r_dropped   <= 1'b0;
      r_flash     <= 1'b0;
      r_flash_cnt <= '0;
    end else begin
      r_changed  <= w_inc;
      r_rollover <= w_tens_carry;
      r_dropped  <= w_drop;
      if (w_accept) begin
        r_flash_cnt <= FLASH_LOAD;
        r_flash     <= 1'b1;
      end else if (r_flash_cnt != '0) begin
        r_flash_cnt <= r_flash_cnt - FW'(1);
      end else begin
        r_flash <= 1'b0;
      end
    end
  end

  assign score_changed = r_changed;
  assign rollover      = r_rollover;
  assign hit_dropped   = r_dropped;
  assign flash         = r_flash;

endmodule

// File: tb/tb_pong_score_keeper.sv
// tb/tb_pong_score_keeper.sv - score keeper bench: three parameter sets against a behavioural model
module tb_pong_score_keeper;

  localparam int F = 8;
  localparam int ML [3] = '{4, 4, 0};
  localparam bit MW [3] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hit = 1'b0;
  logic [3:0] tens [3];
  logic [3:0] ones [3];
  logic chg [3], rol [3], drp [3], fl [3];

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  pong_score_keeper #(.LOCKOUT_CYCLES(4), .FLASH_CYCLES(F), .WRAP(1'b1)) u_a (
    .Clock(clk), .pointresetShot1(rst), .hit_pulse(hit),
    .digit_tens(tens[0]), .digit_ones(ones[0]), .score_changed(chg[0]),
    .rollover(rol[0]), .hit_dropped(drp[0]), .flash(fl[0]));

  pong_score_keeper #(.LOCKOUT_CYCLES(4), .FLASH_CYCLES(F), .WRAP(1'b0)) u_b (
    .Clock(clk), .pointresetShot1(rst), .hit_pulse(hit),
    .digit_tens(tens[1]), .digit_ones(ones[1]), .score_changed(chg[1]),
    .rollover(rol[1]), .hit_dropped(drp[1]), .flash(fl[1]));

  pong_score_keeper #(.LOCKOUT_CYCLES(0), .FLASH_CYCLES(F), .WRAP(1'b1)) u_c (
    .Clock(clk), .pointresetShot1(rst), .hit_pulse(hit),
    .digit_tens(tens[2]), .digit_ones(ones[2]), .score_changed(chg[2]),
    .rollover(rol[2]), .hit_dropped(drp[2]), .flash(fl[2]));

  // Model: score as an integer, lockout as "earliest edge a hit may be accepted",
  // flash as "within F edges of the last accepted hit".
  int m_score [3];
  int m_next_ok [3];
  int m_last [3];
  bit m_chg [3], m_rol [3], m_drp [3];
  int n = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_score[i] = 0; m_next_ok[i] = 0; m_last[i] = -1000;
        m_chg[i] = 0; m_rol[i] = 0; m_drp[i] = 0;
      end
    end else begin
      n = n + 1;
      for (int i = 0; i < 3; i++) begin
        bit acc;
        acc = hit && (n >= m_next_ok[i]);
        m_drp[i] = hit && !acc;
        m_chg[i] = 0;
        m_rol[i] = 0;
        if (acc) begin
          m_next_ok[i] = n + ML[i] + 1;
          m_last[i] = n;
          if (!(m_score[i] == 99 && !MW[i])) begin
            m_chg[i] = 1;
            m_rol[i] = (m_score[i] == 99);
            m_score[i] = (m_score[i] + 1) % 100;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tens[%0d]", i), tens[i], m_score[i] / 10);
        chk($sformatf("ones[%0d]", i), ones[i], m_score[i] % 10);
        chk($sformatf("score_changed[%0d]", i), chg[i], m_chg[i]);
        chk($sformatf("rollover[%0d]", i), rol[i], m_rol[i]);
        chk($sformatf("hit_dropped[%0d]", i), drp[i], m_drp[i]);
        chk($sformatf("flash[%0d]", i), fl[i], int'((n - m_last[i]) < F));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    hit = 1'b1;
    tick();
    hit = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic do_reset();
    hit = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int run;
    bit ended;
    do_reset();
    chk_en = 1'b1;

    // 1: reset state and first hit
    chk("reset_tens", tens[0], 0);
    chk("reset_ones", ones[0], 0);
    chk("reset_flash", fl[0], 0);
    pulse();
    chk("hit1_ones", ones[0], 1);
    chk("hit1_changed", chg[0], 1);
    chk("hit1_flash", fl[0], 1);
    tick();
    chk("hit1_changed_off", chg[0], 0);

    // 2: lockout drop, then accept after lockout
    do_reset();
    pulse();
    tick();
    pulse();
    chk("drop_pulse", drp[0], 1);
    chk("drop_ones", ones[0], 1);
    idle(3);
    pulse();
    chk("third_ones", ones[0], 2);

    // 3: count to 99 then wrap / saturate
    do_reset();
    repeat (99) begin pulse(); idle(5); end
    chk("at99_tens_a", tens[0], 9);
    chk("at99_ones_a", ones[0], 9);
    chk("at99_tens_b", tens[1], 9);
    pulse();
    chk("wrap_tens", tens[0], 0);
    chk("wrap_ones", ones[0], 0);
    chk("wrap_rollover", rol[0], 1);
    chk("sat_ones", ones[1], 9);
    chk("sat_changed", chg[1], 0);
    chk("sat_flash", fl[1], 1);
    idle(5);

    // 4: flash retrigger stays high continuously
    do_reset();
    run = 0;
    ended = 0;
    for (int i = 0; i < 30; i++) begin
      hit = (i == 0 || i == 6);
      tick();
      hit = 1'b0;
      if (fl[0] && !ended) run++;
      else if (run > 0) ended = 1;
    end
    chk("flash_run_len", run, 14);

    // 5: async reset mid-lockout at 47, with a coincident hit
    do_reset();
    repeat (46) begin pulse(); idle(5); end
    pulse();
    chk("pre_reset_tens", tens[0], 4);
    chk("pre_reset_ones", ones[0], 7);
    tick();
    #3;
    hit = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_tens", tens[0], 0);
    chk("async_ones", ones[0], 0);
    chk("async_flash", fl[0], 0);
    tick();
    rst = 1'b0;
    hit = 1'b0;
    tick();
    chk("post_reset_ones", ones[0], 0);

    // 6: no lockout, consecutive hits all count
    do_reset();
    hit = 1'b1;
    idle(5);
    hit = 1'b0;
    chk("nolock_ones", ones[2], 5);
    chk("lock_ones", ones[0], 1);
    idle(3);

    // Random hits with occasional mid-cycle resets
    for (int i = 0; i < 800; i++) begin
      hit = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #3;
        rst = 1'b1;
      end
      tick();
      rst = 1'b0;
    end
    hit = 1'b0;
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
